tri_frame_assembler: RTL
========================

Name: tri_frame_assembler

Overview:
- Upstream stage of the point-in-triangle checker.
- Accepts a serial stream of 12-bit signed coordinate words, eight per test case, in the order x0 y0 x1 y1 x2 y2 x3 y3.
- Presents each complete case as one parallel frame to the checker, using valid/ready on both sides.
- Detects framing errors from a last-word marker and counts the frames it delivers.

Parameters:
- W, 12, coordinate word width (two's complement).
- CNT_W, 16, width of the delivered-frame counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_data  in  W  coordinate word.
- in_valid  in  1  in_data is valid.
- in_last  in  1  marks word 7 (y3) of a frame.
- in_ready  out  1  block accepts in_data this cycle.
- out_x0, out_y0, out_x1, out_y1, out_x2, out_y2, out_x3, out_y3  out  W each  frame fields.
- out_valid  out  1  frame fields valid.
- out_ready  in  1  checker consumes the frame.
- frame_err  out  1  one-cycle pulse on a framing error.
- frame_cnt  out  CNT_W  number of frames consumed; wraps.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - idx=0, state=COLLECT.
  - All out_* fields = 0, out_valid=0, frame_err=0, frame_cnt=0.
  - in_ready is forced to 0 while rst_n=0.
  - Reset mid-frame discards the partial frame and any held frame.
- States:
  - COLLECT: in_ready=1.
  - WAIT: in_ready=0. Complete frame is pending behind an occupied output slot.
- Accept condition: in_valid and in_ready. When idx<7 and in_last=0, store in_data into buffer[idx] and increment idx.
- Word 7 accepted with in_last=1 (frame complete):
  - If the slot is free this cycle (out_valid=0, or out_valid and out_ready): load out_* from buffer[0..6] plus in_data on the same edge. out_valid=1 from the next cycle (latency 1 edge from the last word). idx=0. Stay in COLLECT.
  - Otherwise: store word 7 and go to WAIT.
- WAIT: on the edge where out_valid and out_ready, load the pending frame, keep out_valid=1, idx=0, return to COLLECT.
- Framing errors (the offending word is never stored):
  - Accepted word with in_last=1 and idx<7: frame_err=1 for one cycle, idx=0, partial frame discarded.
  - Accepted word with idx=7 and in_last=0: frame_err=1 for one cycle, idx=0, frame discarded.
  - The output slot is unaffected by either error.
- Output handshake:
  - out_* fields are stable while out_valid=1 and out_ready=0.
  - out_valid deasserts after a consume edge unless a new frame loads on that same edge.
- frame_cnt increments by 1 on every edge with out_valid and out_ready; wraps from 2^CNT_W-1 to 0.
- Words are passed through bit-exact. No sign extension or arithmetic is performed.
- Simultaneous consume and word-7 accept: the new frame loads, out_valid stays 1, frame_cnt increments. Full throughput: one frame every 8 cycles with no bubbles.

Decomposition:
- Shared package holds:
  - COORD_W = 12.
  - FRAME_WORDS = 8.
  - Word index constants IDX_X0..IDX_Y3 = 0..7.
  - State encoding COLLECT/WAIT.
- The downstream checker imports the same COORD_W.
- No sub-module: index counter, 8-word buffer, output slot and FSM form one module.

Test Plan:
1. Reset, then stream 3,1, 0,0, 10,0, 0,10 with in_last on the 8th word and out_ready=1 → out_valid=1 one cycle after the 8th accept; fields x0=3, y0=1, x1=0, y1=0, x2=10, y2=0, x3=0, y3=10; frame_cnt=1 after consume.
2. Negative values -5 (0xFFB) and -2048 (0x800) → bit-exact on outputs; check a field at 2047 (0x7FF).
3. out_ready=0 while a second frame completes → in_ready=0 after its 8th word, state WAIT, first frame held stable; raise out_ready → second frame appears next cycle, in_ready=1, frame_cnt=1 then 2.
4. in_last=1 on the 5th word → frame_err pulses exactly 1 cycle, nothing delivered; the next 8 good words deliver a correct frame.
5. 8th word with in_last=0 → frame_err pulse, no out_valid; stream continues and resyncs.
6. Preload frame_cnt via 65535 consumes (or a reduced-CNT_W build with CNT_W=4, 15 consumes) → next consume wraps to 0. Separately, drive rst_n=0 mid-frame at idx=4 → out_valid=0, idx=0, and the next full frame is correct.

Source files
------------

// File: rtl/tri_frame_assembler_pkg.sv
// Shared definitions for the point-in-triangle front end.
//   COORD_W      : coordinate word width, also imported by the downstream checker
//   FRAME_WORDS  : words per test case (x0 y0 x1 y1 x2 y2 x3 y3)
//   IDX_*        : position of each coordinate within a frame
//   state_e      : assembler FSM encoding
package tri_frame_assembler_pkg;

  localparam int unsigned COORD_W     = 12;
  localparam int unsigned FRAME_WORDS = 8;
  localparam int unsigned IDX_W       = $clog2(FRAME_WORDS);

  localparam int unsigned IDX_X0 = 0;
  localparam int unsigned IDX_Y0 = 1;
  localparam int unsigned IDX_X1 = 2;
  localparam int unsigned IDX_Y1 = 3;
  localparam int unsigned IDX_X2 = 4;
  localparam int unsigned IDX_Y2 = 5;
  localparam int unsigned IDX_X3 = 6;
  localparam int unsigned IDX_Y3 = 7;

  typedef enum logic {
    COLLECT = 1'b0,
    WAIT    = 1'b1
  } state_e;

endpackage

// File: rtl/tri_frame_assembler.sv
// Serial-to-parallel frame assembler: gathers eight coordinate words into one
// frame and hands it to the checker over valid/ready.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_data/valid/last    : serial coordinate stream, in_last marks word 7 (y3)
//   in_ready              : word accepted this cycle when in_valid is also high
//   out_x0..out_y3        : frame fields, stable while out_valid && !out_ready
//   out_valid/out_ready   : frame handshake
//   frame_err             : one-cycle pulse when in_last disagrees with position
//   frame_cnt             : count of consumed frames, wraps
module tri_frame_assembler
  import tri_frame_assembler_pkg::*;
#(
  parameter int unsigned W     = COORD_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [W-1:0]     out_x0,
  output logic [W-1:0]     out_y0,
  output logic [W-1:0]     out_x1,
  output logic [W-1:0]     out_y1,
  output logic [W-1:0]     out_x2,
  output logic [W-1:0]     out_y2,
  output logic [W-1:0]     out_x3,
  output logic [W-1:0]     out_y3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IDX_Y3);

  state_e                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [FRAME_WORDS-1:0][W-1:0] word_q, word_d;
  logic [FRAME_WORDS-1:0][W-1:0] out_q, out_d;
  logic                          out_valid_q, out_valid_d;
  logic                          frame_err_q, frame_err_d;
  logic [CNT_W-1:0]              frame_cnt_q, frame_cnt_d;

  logic accept;
  logic consume;
  logic slot_free;
  logic at_last;

  // in_ready must drop while reset is held, hence the direct rst_n term
  assign in_ready  = rst_n && (state_q == COLLECT);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid_q && out_ready;
  assign slot_free = !out_valid_q || out_ready;
  assign at_last   = (idx_q == LAST_IDX);

  // Next-state: index counter, buffer, output slot and counter
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    word_d      = word_q;
    out_d       = out_q;
    out_valid_d = out_valid_q && !out_ready;
    frame_err_d = 1'b0;
    frame_cnt_d = consume ? frame_cnt_q + CNT_W'(1) : frame_cnt_q;

    case (state_q)
      COLLECT: begin
        if (accept) begin
          // in_last must be high exactly on word 7; either mismatch drops the frame
          if (at_last != in_last) begin
            frame_err_d = 1'b1;
            idx_d       = '0;
          end else if (!at_last) begin
            word_d[idx_q] = in_data;
            idx_d         = idx_q + IDX_W'(1);
          end else if (slot_free) begin
            out_d           = word_q;
            out_d[LAST_IDX] = in_data;
            out_valid_d     = 1'b1;
            idx_d           = '0;
          end else begin
            word_d[LAST_IDX] = in_data;
            state_d          = WAIT;
          end
        end
      end
      WAIT: begin
        if (consume) begin
          out_d       = word_q;
          out_valid_d = 1'b1;
          idx_d       = '0;
          state_d     = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      idx_q       <= '0;
      word_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign out_x0    = out_q[IDX_X0];
  assign out_y0    = out_q[IDX_Y0];
  assign out_x1    = out_q[IDX_X1];
  assign out_y1    = out_q[IDX_Y1];
  assign out_x2    = out_q[IDX_X2];
  assign out_y2    = out_q[IDX_Y2];
  assign out_x3    = out_q[IDX_X3];
  assign out_y3    = out_q[IDX_Y3];
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule
